riscv_lsu: RTL and testbench

Load/store unit between the RISC-V core datapath and the data-memory bus. It takes the memory request produced by the main decoder (request, write enable, LDST size), runs one bus transaction per request, and holds the core in stall until that transaction completes. On the store path it generates byte enables and lane-replicated write data. On the load path it extracts the addressed byte or halfword and sign- or zero-extends it.

---
 rtl/riscv_lsu.sv | 164 ++++++++++++++++
 tb/tb_riscv_lsu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
// Load/store unit: one data-bus transaction per core memory request, with
// store lane replication / byte enables and load lane extraction / extension.
module riscv_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_req_o,
  output logic        misaligned_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic        err_q, err_d;
  logic [31:0] rd_q, rd_d;

  logic        illegal;
  logic [3:0]  be_calc;
  logic [31:0] wd_calc;
  logic [15:0] lane;
  logic [31:0] rd_ext;

  // Request decode: legality, byte enables and replicated store data.
  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    illegal = 1'b0;
    be_calc = 4'b0000;
    wd_calc = core_wd_i;
    case (core_size_i)
      LDST_B, LDST_BU: begin
        be_calc = 4'b0001 << core_addr_i[1:0];
        wd_calc = {4{core_wd_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        illegal = core_addr_i[0];
        be_calc = core_addr_i[1] ? 4'b1100 : 4'b0011;
        wd_calc = {2{core_wd_i[15:0]}};
      end
      LDST_W: begin
        illegal = (core_addr_i[1:0] != 2'b00);
        be_calc = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
    if (core_we_i && (core_size_i == LDST_BU || core_size_i == LDST_HU))
      illegal = 1'b1;
  end

  // Load path: shift the addressed lane down, then extend by latched size.
  always_comb begin
    lane   = 16'(mem_rd_i >> {addr_q[1:0], 3'b000});
    rd_ext = mem_rd_i;
    case (size_q)
      LDST_B:  rd_ext = {{24{lane[7]}}, lane[7:0]};
      LDST_BU: rd_ext = {24'h0, lane[7:0]};
      LDST_H:  rd_ext = {{16{lane[15]}}, lane};
      LDST_HU: rd_ext = {16'h0, lane};
      default: rd_ext = mem_rd_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    err_d   = err_q;
    rd_d    = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (core_req_i) begin
          err_d = illegal;
          if (illegal) begin
            state_d = ST_RESP;
          end else begin
            we_d    = core_we_i;
            size_d  = core_size_i;
            addr_d  = core_addr_i;
            be_d    = be_calc;
            wd_d    = wd_calc;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_ready_i) begin
          if (!we_q) rd_d = rd_ext;
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next-state value from the same pre-edge snapshot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= LDST_B;
      addr_q  <= 32'h0;
      be_q    <= 4'b0000;
      wd_q    <= 32'h0;
      err_q   <= 1'b0;
      rd_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    core_stall_req_o = 1'b0;
    case (state_q)
      ST_IDLE: core_stall_req_o = core_req_i;
      ST_REQ:  core_stall_req_o = 1'b1;
      default: core_stall_req_o = 1'b0;
    endcase
  end

  assign misaligned_o = (state_q == ST_RESP) && err_q;
  assign mem_req_o    = (state_q == ST_REQ);
  assign mem_we_o     = we_q;
  assign mem_be_o     = be_q;
  assign mem_addr_o   = addr_q;
  assign mem_wd_o     = wd_q;
  assign core_rd_o    = rd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: loads, stores, illegal accesses, and
// synchronous reset landing in the middle of a bus transaction.
module tb_riscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_req_o;
  logic        misaligned_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  riscv_lsu dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .core_req_i       (core_req_i),
    .core_we_i        (core_we_i),
    .core_size_i      (core_size_i),
    .core_addr_i      (core_addr_i),
    .core_wd_i        (core_wd_i),
    .core_rd_o        (core_rd_o),
    .core_stall_req_o (core_stall_req_o),
    .misaligned_o     (misaligned_o),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .mem_be_o         (mem_be_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wd_o         (mem_wd_o),
    .mem_rd_i         (mem_rd_i),
    .mem_ready_i      (mem_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one access from IDLE to RESP, answering the bus after n_wait extra
  // REQ cycles. Inputs change 1 time unit after the edge; outputs are sampled
  // 2 units after the edge, well clear of the next rising edge.
  task automatic access(input string tag, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int n_wait,
                        input logic [31:0] exp_rd, input int exp_stall,
                        input logic exp_mis, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd);
    int          stall_n = 0;
    int          total   = 0;
    int          req_n   = 0;
    int          mis_at  = -1;
    bit          done    = 0;
    logic [3:0]  be_s    = 4'h0;
    logic [31:0] wd_s    = 32'h0;
    logic [31:0] addr_s  = 32'h0;
    logic        we_s    = 1'b0;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    mem_rd_i    = rdata;
    core_req_i  = 1'b1;
    while (!done && total < 20) begin
      #1;
      if (core_stall_req_o) stall_n++;
      else done = 1;
      if (misaligned_o) mis_at = total;
      if (mem_req_o) begin
        be_s   = mem_be_o;
        wd_s   = mem_wd_o;
        addr_s = mem_addr_o;
        we_s   = mem_we_o;
        if (req_n == n_wait) mem_ready_i = 1'b1;
        req_n++;
      end
      total++;
      tick();
      mem_ready_i = 1'b0;
      if (done) core_req_i = 1'b0;
    end
    core_req_i = 1'b0;
    #1;
    check({tag, " completed"}, 32'(done), 32'd1);
    check({tag, " stall cycles"}, stall_n, exp_stall);
    check({tag, " total cycles"}, total, exp_stall + 1);
    check({tag, " misaligned cycle"}, mis_at, exp_mis ? exp_stall : -1);
    check({tag, " mem_req cycles"}, req_n, exp_mis ? 0 : n_wait + 1);
    check({tag, " core_rd"}, core_rd_o, exp_rd);
    check({tag, " idle stall"}, 32'(core_stall_req_o), 32'd0);
    if (!exp_mis) begin
      check({tag, " be"}, 32'(be_s), 32'(exp_be));
      check({tag, " wd"}, wd_s, exp_wd);
      check({tag, " addr"}, addr_s, addr);
      check({tag, " we"}, 32'(we_s), 32'(we));
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    core_req_i  = 1'b0;
    core_we_i   = 1'b0;
    core_size_i = 3'd0;
    core_addr_i = 32'h0;
    core_wd_i   = 32'h0;
    mem_rd_i    = 32'h0;
    mem_ready_i = 1'b0;
    tick();
    tick();
    check("reset mem_req", 32'(mem_req_o), 32'd0);
    check("reset mem_we", 32'(mem_we_o), 32'd0);
    check("reset mem_be", 32'(mem_be_o), 32'd0);
    check("reset mem_addr", mem_addr_o, 32'h0);
    check("reset mem_wd", mem_wd_o, 32'h0);
    check("reset core_rd", core_rd_o, 32'h0);
    check("reset misaligned", 32'(misaligned_o), 32'd0);
    check("reset stall low", 32'(core_stall_req_o), 32'd0);
    core_req_i = 1'b1;
    #1;
    check("reset stall follows req", 32'(core_stall_req_o), 32'd1);
    core_req_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();

    //      tag    we    size  addr          wd            rdata         wait exp_rd        stall mis   be       wd
    access("LB",   1'b0, 3'd0, 32'h0000_1002, 32'h0,        32'h12F4_5678, 2, 32'hFFFF_FFF4, 4, 1'b0, 4'b0100, 32'h0);
    access("LHU",  1'b0, 3'd5, 32'h0000_2002, 32'h0,        32'h8001_ABCD, 0, 32'h0000_8001, 2, 1'b0, 4'b1100, 32'h0);
    access("SB",   1'b1, 3'd0, 32'h0000_3003, 32'h0000_00A5, 32'h5555_5555, 0, 32'h0000_8001, 2, 1'b0, 4'b1000, 32'hA5A5_A5A5);
    access("SH",   1'b1, 3'd1, 32'h0000_3002, 32'h1234_BEEF, 32'h5555_5555, 1, 32'h0000_8001, 3, 1'b0, 4'b1100, 32'hBEEF_BEEF);
    access("LWmis",1'b0, 3'd2, 32'h0000_4001, 32'h0,        32'h7777_7777, 0, 32'h0000_8001, 1, 1'b1, 4'b0000, 32'h0);
    access("SBU",  1'b1, 3'd4, 32'h0000_3000, 32'h0000_0011, 32'h7777_7777, 0, 32'h0000_8001, 1, 1'b1, 4'b0000, 32'h0);
    access("LH",   1'b0, 3'd1, 32'h0000_5000, 32'h0,        32'h1234_8765, 0, 32'hFFFF_8765, 2, 1'b0, 4'b0011, 32'h0);
    access("LW0",  1'b0, 3'd2, 32'h0000_0000, 32'h0,        32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 2, 1'b0, 4'b1111, 32'h0);

    // Reset and bus completion land in the same REQ cycle: reset wins.
    core_we_i   = 1'b0;
    core_size_i = 3'd0;
    core_addr_i = 32'h0000_1003;
    mem_rd_i    = 32'h8000_0000;
    core_req_i  = 1'b1;
    tick();
    check("rst+ready in REQ", 32'(mem_req_o), 32'd1);
    rst_i       = 1'b1;
    mem_ready_i = 1'b1;
    tick();
    rst_i       = 1'b0;
    mem_ready_i = 1'b0;
    core_req_i  = 1'b0;
    #1;
    check("rst+ready core_rd", core_rd_o, 32'h0);
    check("rst+ready mem_req", 32'(mem_req_o), 32'd0);
    check("rst+ready stall", 32'(core_stall_req_o), 32'd0);
    tick();

    access("LW1",  1'b0, 3'd2, 32'h0000_0000, 32'h0,        32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 2, 1'b0, 4'b1111, 32'h0);

    // Reset one cycle into REQ, late bus completion on the following cycle.
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h0;
    mem_rd_i    = 32'h1111_2222;
    core_req_i  = 1'b1;
    tick();
    tick();
    check("midreq mem_req", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i       = 1'b0;
    mem_ready_i = 1'b1;
    core_req_i  = 1'b0;
    #1;
    check("midreq after rst mem_req", 32'(mem_req_o), 32'd0);
    check("midreq after rst stall", 32'(core_stall_req_o), 32'd0);
    check("midreq after rst core_rd", core_rd_o, 32'h0);
    check("midreq after rst be", 32'(mem_be_o), 32'd0);
    tick();
    mem_ready_i = 1'b0;
    #1;
    check("midreq late ready mem_req", 32'(mem_req_o), 32'd0);
    check("midreq late ready core_rd", core_rd_o, 32'h0);
    check("midreq late ready misaligned", 32'(misaligned_o), 32'd0);
    tick();

    access("LWpost",1'b0, 3'd2, 32'h0000_0000, 32'h0,       32'hCAFE_F00D, 1, 32'hCAFE_F00D, 3, 1'b0, 4'b1111, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
